product_accumulator: RTL and testbench

//  Sequential stage directly downstream of multiplier_4bit.

---
 rtl/product_accumulator.sv | 129 ++++++++++++
 tb/tb_product_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of 8-bit products from a valid/ready stream
// and presents the wrapped sum plus a sticky overflow flag on a second handshake.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Extra top bit of the sum is the carry-out that feeds the sticky overflow.
  logic [ACC_W:0]   sum_s;
  logic             last_beat_s;

  assign sum_s       = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};
  assign last_beat_s = (count_q == (len_q - LEN_ONE));

  // Next-state and datapath update; handshake outputs are decoded from the next state so they leave flops.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = ACC_ZERO;
          ovf_d   = 1'b0;
          count_d = LEN_ZERO;
          if (len == LEN_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (in_valid && in_ready_q) begin
          acc_d   = sum_s[ACC_W-1:0];
          ovf_d   = ovf_q | sum_s[ACC_W];
          count_d = count_q + LEN_ONE;
          if (last_beat_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      ovf_q       <= 1'b0;
      count_q     <= LEN_ZERO;
      len_q       <= LEN_ZERO;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 12-bit and an 8-bit accumulator share one stimulus stream;
// expected results come from plain integer sums of the issued products.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  prod;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, ovf, out_valid, busy;
  logic [11:0] acc;
  logic        in_ready8, ovf8, out_valid8, busy8;
  logic [7:0]  acc8;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int prods[16];
  int mon_e;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(12), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready), .acc(acc), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  product_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready8), .acc(acc8), .ovf(ovf8),
    .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake pops one expected total.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_acc12", int'(acc), mon_e % 4096);
          check("sb_ovf12", int'(ovf), int'(mon_e >= 4096));
          check("sb_acc8", int'(acc8), mon_e % 256);
          check("sb_ovf8", int'(ovf8), int'(mon_e >= 256));
          check("sb_valid8", int'(out_valid8), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // vmode: 0 = in_valid always high, 1 = random, 2 = pattern from vpat bits
  task automatic do_run(input int n, input int vmode, input int vpat,
                        input int hold, input bit start_on_exit);
    int sum = 0;
    int i   = 0;
    int cyc = 0;
    for (int k = 0; k < n; k++) sum += prods[k];
    @(posedge clk); #1;
    start     = 1'b1;
    len       = 4'(n);
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 4'($urandom_range(0, 15));
    check("busy_after_start", int'(busy), 1);
    check("in_ready_after_start", int'(in_ready), int'(n != 0));
    while (i < n && cyc < 200) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = vpat[cyc % 32];
      endcase
      prod = in_valid ? 8'(prods[i]) : 8'($urandom);
      check("in_ready_acc", int'(in_ready), 1);
      @(posedge clk); #1;
      if (in_valid) i++;
      cyc++;
    end
    if (cyc >= 200) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
    exp_q.push_back(sum);
    check("out_valid_latency", int'(out_valid), 1);
    check("in_ready_done", int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      start     = (h == 1);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_acc", int'(acc), sum % 4096);
      check("hold_in_ready", int'(in_ready), 0);
    end
    start     = start_on_exit;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    check("idle_valid", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_acc_kept", int'(acc), sum % 4096);
    check("idle_acc8_kept", int'(acc8), sum % 256);
    check("idle_ovf8_kept", int'(ovf8), int'(sum >= 256));
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    prod      = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_acc", int'(acc), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    prods[0] = 10; prods[1] = 20; prods[2] = 30;
    do_run(3, 0, 0, 0, 1'b0);

    do_run(0, 0, 0, 0, 1'b0);

    prods[0] = 225; prods[1] = 225;
    do_run(2, 2, 32'h9, 0, 1'b0);

    for (int k = 0; k < 4; k++) prods[k] = $urandom_range(0, 15) * $urandom_range(0, 15);
    do_run(4, 0, 0, 5, 1'b1);

    prods[0] = 225; prods[1] = 225;
    do_run(2, 0, 0, 0, 1'b0);

    // Asynchronous reset two beats into a four-beat run.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 4'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    prod     = 8'd50;
    @(posedge clk); #1;
    prod = 8'd60;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_acc", int'(acc), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_in_ready", int'(in_ready), 0);
    check("async_rst_acc8", int'(acc8), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prods[0] = 7; prods[1] = 8; prods[2] = 9;
    do_run(3, 0, 0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) prods[k] = $urandom_range(0, 15) * $urandom_range(0, 15);
      do_run(n, $urandom_range(0, 1), 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
